// File: rtl/numero_source.sv
// Handshake data source for the pulse-former consumer: a host-filled FIFO drained one entry per soc/eoc handshake.
// Optional build macro NUMERO_ZERO_CLAMP_EN: pushed zeros are stored as one.
module numero_source #(
    parameter int         DEPTH      = 4,
    parameter logic [7:0] INIT_VALUE = 8'd6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     soc,
    output logic                     eoc,
    output logic [7:0]               numero,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_eoc;
    logic            w_eoc_nxt;
    logic [7:0]      r_numero;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_overflow;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic [7:0]      w_store_data;

    // The consumer cannot form a zero-length pulse, so a zero may be promoted to one.
    function automatic logic [7:0] store_value(input logic [7:0] d);
`ifdef NUMERO_ZERO_CLAMP_EN
        return (d == 8'd0) ? 8'd1 : d;
`else
        return d;
`endif
    endfunction

    assign w_empty      = (r_level == {LW{1'b0}});
    assign w_full       = (r_level == DEPTH_L);
    assign w_pop        = (r_state == ST_FETCH) && !w_empty;
    assign w_push       = wr_en && (!w_full || w_pop);
    assign w_store_data = store_value(wr_data);

    // Handshake next-state and next-eoc decode.
    always_comb begin
        w_state_nxt = r_state;
        w_eoc_nxt   = r_eoc;
        case (r_state)
            ST_IDLE: begin
                if (soc) begin
                    w_state_nxt = ST_ACK;
                    w_eoc_nxt   = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_eoc_nxt   = 1'b1;
                end
            end
            ST_ACK: begin
                w_eoc_nxt = 1'b0;
                if (!soc) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_FETCH: begin
                if (w_pop) begin
                    w_state_nxt = ST_IDLE;
                    w_eoc_nxt   = 1'b1;
                end else begin
                    w_state_nxt = ST_FETCH;
                    w_eoc_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_eoc_nxt   = 1'b1;
            end
        endcase
    end

    // Handshake state, registered outputs and FIFO bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_eoc      <= 1'b1;
            r_numero   <= INIT_VALUE;
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_level    <= {LW{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_eoc      <= w_eoc_nxt;
            r_overflow <= wr_en && w_full && !w_pop;
            if (w_pop) begin
                r_numero <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_store_data;
        end
    end

    assign eoc      = r_eoc;
    assign numero   = r_numero;
    assign level    = r_level;
    assign full     = w_full;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_numero_source.sv
// Directed bench for numero_source: a scoreboard queue holds the values expected back from each handshake.
module tb_numero_source;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          soc;
    logic          eoc;
    logic [7:0]    numero;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic [LW-1:0] level;
    logic          overflow;

    int            checks = 0;
    int            errors = 0;
    int            mlevel = 0;
    logic [7:0]    sb[$];

    numero_source #(.DEPTH(DEPTH), .INIT_VALUE(8'd6)) dut (
        .clock    (clock),
        .reset    (reset),
        .soc      (soc),
        .eoc      (eoc),
        .numero   (numero),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_store(input logic [7:0] d);
`ifdef NUMERO_ZERO_CLAMP_EN
        return (d == 8'd0) ? 8'd1 : d;
`else
        return d;
`endif
    endfunction

    // Single-cycle push; bench model decides acceptance (no pop assumed on this edge).
    task automatic push(input logic [7:0] d, input string tag);
        logic exp_ovf;
        wr_en   = 1'b1;
        wr_data = d;
        if (mlevel < DEPTH) begin
            sb.push_back(model_store(d));
            mlevel++;
            exp_ovf = 1'b0;
        end else begin
            exp_ovf = 1'b1;
        end
        tick();
        wr_en = 1'b0;
        chk({tag, "_level"}, 32'(level), 32'(mlevel));
        chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    endtask

    // Complete handshake; returns edges from the soc-low edge to eoc rising.
    task automatic handshake(input string tag, output int lat);
        logic [7:0] exp;
        soc = 1'b1;
        tick();
        chk({tag, "_ack_eoc"}, 32'(eoc), 32'd0);
        soc = 1'b0;
        lat = 0;
        while (eoc !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        chk({tag, "_eoc"}, 32'(eoc), 32'd1);
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            mlevel--;
            chk({tag, "_numero"}, 32'(numero), 32'(exp));
        end else begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end
        chk({tag, "_level"}, 32'(level), 32'(mlevel));
    endtask

    initial begin
        int lat;
        logic [7:0] exp;
        reset   = 1'b1;
        soc     = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'd0;

        // Reset state
        tick();
        tick();
        chk("rst_eoc", 32'(eoc), 32'd1);
        chk("rst_numero", 32'(numero), 32'd6);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();

        // Basic handshake
        push(8'd3, "basic_push");
        handshake("basic", lat);
        chk("basic_latency", 32'(lat), 32'd2);

        // Empty stall, then a late push releases the consumer
        soc = 1'b1;
        tick();
        soc = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_eoc", 32'(eoc), 32'd0);
        end
        push(8'd9, "stall_push");
        chk("stall_eoc_at_push", 32'(eoc), 32'd0);
        tick();
        exp = sb.pop_front();
        mlevel--;
        chk("stall_release_eoc", 32'(eoc), 32'd1);
        chk("stall_numero", 32'(numero), 32'(exp));
        chk("stall_level", 32'(level), 32'(mlevel));

        // Fill past capacity: one dropped push
        for (int v = 1; v <= 5; v++) begin
            push(8'(v), "fill");
        end
        tick();
        chk("fill_ovf_once", 32'(overflow), 32'd0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd4);

        // Full with push and pop on the same edge
        soc = 1'b1;
        tick();
        soc = 1'b0;
        tick();
        chk("pp_fetch_eoc", 32'(eoc), 32'd0);
        wr_en   = 1'b1;
        wr_data = 8'd7;
        tick();
        wr_en = 1'b0;
        exp = sb.pop_front();
        sb.push_back(model_store(8'd7));
        chk("pp_eoc", 32'(eoc), 32'd1);
        chk("pp_numero", 32'(numero), 32'(exp));
        chk("pp_level", 32'(level), 32'd4);
        chk("pp_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            handshake("drain", lat);
        end
        chk("drain_full", 32'(full), 32'd0);

        // Reset while in ACK with two entries queued
        push(8'd10, "mid_push");
        push(8'd11, "mid_push");
        soc = 1'b1;
        tick();
        chk("mid_ack_eoc", 32'(eoc), 32'd0);
        reset = 1'b1;
        soc   = 1'b0;
        tick();
        reset = 1'b0;
        sb.delete();
        mlevel = 0;
        chk("mid_rst_eoc", 32'(eoc), 32'd1);
        chk("mid_rst_numero", 32'(numero), 32'd6);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_full", 32'(full), 32'd0);

        // Zero value, clamped or verbatim depending on build
        push(8'd0, "zero_push");
        handshake("zero", lat);
`ifdef NUMERO_ZERO_CLAMP_EN
        chk("zero_value", 32'(numero), 32'd1);
`else
        chk("zero_value", 32'(numero), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
